pe_ring_spad: RTL and testbench

Parametrised PE scratchpad; successor to the single-mode filter scratchpad. Two run-time modes:
- LINEAR (filter weights): write once, read many by absolute address.
- RING (ifmap / psum sliding window): circular FIFO with window-relative reads and multi-entry pop, so the window slides by the row stride without reloading.

It sits inside each PE beside the MAC datapath and is driven by the PE control FSM. Adds occupancy tracking, wrap-around, valid-qualified reads and sticky error flags.

---
 rtl/pe_spad_pkg.sv | 22 ++
 rtl/spad_mem.sv | 35 +++
 rtl/pe_ring_spad.sv | 116 +++++++++++
 tb/tb_pe_ring_spad.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_spad_pkg.sv
// Shared constants and modular-arithmetic helpers for the PE scratchpad.
// Pointer math uses a single conditional subtract, so operands must stay below 2*d.
package pe_spad_pkg;

  localparam logic SPAD_MODE_LINEAR = 1'b0;
  localparam logic SPAD_MODE_RING   = 1'b1;

  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned d);
    int unsigned s;
    s = a + b;
    return (s >= d) ? (s - d) : s;
  endfunction

  // A requested depth of 0, or one larger than the array, means "use the whole array".
  function automatic int unsigned clamp_depth(input int unsigned req,
                                              input int unsigned max_depth);
    return ((req == 0) || (req > max_depth)) ? max_depth : req;
  endfunction

endpackage

// File: rtl/spad_mem.sv
// 1W1R scratchpad array: falling-edge write, registered falling-edge read.
// The read register holds its value when no read is issued.
module spad_mem #(
  parameter int MEM_DEPTH  = 224,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents are undefined after reset.
  always_ff @(negedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset)        rdata_q <= '0;
    else if (clear_i) rdata_q <= '0;
    else if (re_i)    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pe_ring_spad.sv
// PE scratchpad with LINEAR (absolute-address) and RING (sliding-window FIFO) modes.
// Holds the write pointer, window head, occupancy and sticky error flags.
module pe_ring_spad
  import pe_spad_pkg::*;
#(
  parameter int MEM_DEPTH  = 224,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int CNT_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [CNT_WIDTH-1:0]  spad_depth,
  input  logic                  clear,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] r_offset,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  pop,
  input  logic [CNT_WIDTH-1:0]  pop_cnt,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  logic [CNT_WIDTH-1:0]  depth_eff;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_unf_q, err_unf_d;
  logic                  dout_valid_q;
  logic                  ring, wr_acc, rd_ok, pop_req, pop_acc;

  assign depth_eff = CNT_WIDTH'(clamp_depth(32'(spad_depth), 32'(MEM_DEPTH)));
  assign full      = (count_q == depth_eff);
  assign empty     = (count_q == '0);
  assign ring      = (mode == SPAD_MODE_RING);

  // Space freed by a same-edge pop is deliberately not visible to the write.
  assign wr_acc  = w_en && !full;
  assign rd_ok   = r_en && (32'(r_offset) < 32'(count_q));
  assign pop_req = ring && pop && (pop_cnt != '0);
  assign pop_acc = pop_req && (pop_cnt <= count_q);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    wr_ptr_d  = wr_ptr_q;
    head_d    = head_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    rd_addr   = ring ? ADDR_WIDTH'(wrap_add(32'(head_q), 32'(r_offset), 32'(depth_eff)))
                     : r_offset;

    if (wr_acc)         wr_ptr_d  = ADDR_WIDTH'(wrap_add(32'(wr_ptr_q), 32'd1, 32'(depth_eff)));
    if (w_en && full)   err_ovf_d = 1'b1;
    if (pop_acc)        head_d    = ADDR_WIDTH'(wrap_add(32'(head_q), 32'(pop_cnt), 32'(depth_eff)));
    if (pop_req && !pop_acc) err_unf_d = 1'b1;

    count_d = count_q + CNT_WIDTH'(wr_acc) - (pop_acc ? pop_cnt : '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      head_q       <= '0;
      err_ovf_q    <= 1'b0;
      err_unf_q    <= 1'b0;
      dout_valid_q <= 1'b0;
    end else if (clear) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      head_q       <= '0;
      err_ovf_q    <= 1'b0;
      err_unf_q    <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      head_q       <= head_d;
      err_ovf_q    <= err_ovf_d;
      err_unf_q    <= err_unf_d;
      dout_valid_q <= rd_ok;
    end
  end

  spad_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .clear_i(clear),
    .we_i   (wr_acc && !clear),
    .waddr_i(wr_ptr_q),
    .wdata_i(din),
    .re_i   (rd_ok && !clear),
    .raddr_i(rd_addr),
    .rdata_o(dout)
  );

  assign count         = count_q;
  assign dout_valid    = dout_valid_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_pe_ring_spad.sv
// Scoreboard bench for pe_ring_spad: a behavioural model predicts state each falling edge,
// expected read data is queued at stimulus time and popped when the read result is due.
module tb_pe_ring_spad;

  localparam int MEM_DEPTH = 224;
  localparam int DW        = 16;
  localparam int AW        = 8;
  localparam int CW        = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mode = 1'b0;
  logic [CW-1:0] spad_depth = '0;
  logic          clear = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          r_en = 1'b0;
  logic [AW-1:0] r_offset = '0;
  logic          pop = 1'b0;
  logic [CW-1:0] pop_cnt = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [CW-1:0] count;
  logic          full, empty, err_overflow, err_underflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_mem [MEM_DEPTH];
  int            m_wr, m_head, m_cnt, m_d;
  bit            m_ovf, m_unf, m_vld;
  logic [DW-1:0] m_dout;

  pe_ring_spad dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .spad_depth   (spad_depth),
    .clear        (clear),
    .w_en         (w_en),
    .din          (din),
    .r_en         (r_en),
    .r_offset     (r_offset),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .pop          (pop),
    .pop_cnt      (pop_cnt),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_wr = 0; m_head = 0; m_cnt = 0;
    m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0;
    m_dout = '0;
    exp_q.delete();
  endtask

  task automatic set_cfg(input bit m, input int sd);
    mode       = m;
    spad_depth = CW'(sd);
    m_d        = ((sd == 0) || (sd > MEM_DEPTH)) ? MEM_DEPTH : sd;
  endtask

  task automatic check_state();
    check("count",     32'(count),         32'(m_cnt));
    check("full",      32'(full),          32'(m_cnt == m_d));
    check("empty",     32'(empty),         32'(m_cnt == 0));
    check("overflow",  32'(err_overflow),  32'(m_ovf));
    check("underflow", 32'(err_underflow), 32'(m_unf));
  endtask

  task automatic cycle(input bit we, input int d, input bit re, input int off,
                       input bit po, input int pc, input bit clr);
    bit m_full, rd_ok;
    int inc, dec, addr;
    w_en = we; din = DW'(d); r_en = re; r_offset = AW'(off);
    pop = po; pop_cnt = CW'(pc); clear = clr;
    m_full = (m_cnt == m_d);
    if (clr) begin
      model_reset();
    end else begin
      rd_ok = re && (off < m_cnt);
      m_vld = rd_ok;
      if (rd_ok) begin
        addr = mode ? ((m_head + off) % m_d) : off;
        exp_q.push_back(m_mem[addr]);
      end
      inc = 0; dec = 0;
      if (we) begin
        if (!m_full) begin
          m_mem[m_wr] = DW'(d);
          m_wr = (m_wr + 1) % m_d;
          inc = 1;
        end else m_ovf = 1'b1;
      end
      if (mode && po && (pc != 0)) begin
        if (pc > m_cnt) m_unf = 1'b1;
        else begin
          m_head = (m_head + pc) % m_d;
          dec = pc;
        end
      end
      m_cnt = m_cnt + inc - dec;
    end
    @(negedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; pop = 1'b0; clear = 1'b0;
    check("dout_valid", 32'(dout_valid), 32'(m_vld));
    if (exp_q.size() != 0) begin
      m_dout = exp_q.pop_front();
      check("dout", 32'(dout), 32'(m_dout));
    end else begin
      check("dout_hold", 32'(dout), 32'(m_dout));
    end
    check_state();
  endtask

  task automatic wr(input int d);
    cycle(1'b1, d, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int off);
    cycle(1'b0, 0, 1'b1, off, 1'b0, 0, 1'b0);
  endtask

  task automatic pp(input int n);
    cycle(1'b0, 0, 1'b0, 0, 1'b1, n, 1'b0);
  endtask

  initial begin
    model_reset();
    set_cfg(1'b0, 4);
    #3;
    check("reset.dout", 32'(dout), 32'h0);
    check("reset.dout_valid", 32'(dout_valid), 32'h0);
    check_state();
    reset = 1'b0;

    // LINEAR, depth 4: fill, read by address, overflow, pop ignored
    for (int i = 0; i < 4; i++) wr(16'hA + i);
    check("t1.full", 32'(full), 32'h1);
    rd(2);
    check("t1.read2", 32'(dout), 32'hC);
    wr(16'hE);
    check("t1.ovf", 32'(err_overflow), 32'h1);
    cycle(1'b0, 0, 1'b0, 0, 1'b1, 2, 1'b0);
    rd(3);
    rd(4);
    cycle(1'b1, 16'h55, 1'b0, 0, 1'b0, 0, 1'b1);

    // RING, depth 5: pop slides the window, writes wrap
    set_cfg(1'b1, 5);
    for (int i = 1; i <= 5; i++) wr(i);
    pp(2);
    check("t2.count", 32'(count), 32'd3);
    rd(0);
    check("t2.read0", 32'(dout), 32'd3);
    wr(6);
    wr(7);
    rd(4);
    check("t2.read4", 32'(dout), 32'd7);

    // RING: out-of-window read, underflowing pop, wrapped read
    pp(2);
    rd(3);
    check("t3.hold", 32'(dout), 32'd7);
    pp(4);
    check("t3.unf", 32'(err_underflow), 32'h1);
    rd(1);

    // RING full: write and pop on the same edge
    wr(8);
    wr(9);
    cycle(1'b1, 99, 1'b0, 0, 1'b1, 1, 1'b0);
    check("t4.count", 32'(count), 32'd4);

    // clear with data and sticky flags present, simultaneous write ignored
    pp(1);
    cycle(1'b1, 16'h77, 1'b0, 0, 1'b0, 0, 1'b1);
    check("t6.count", 32'(count), 32'd0);
    rd(0);

    // async reset between edges with a read pending
    for (int i = 11; i <= 16; i++) wr(i);
    rd(2);
    pp(9);
    r_en = 1'b1;
    r_offset = AW'(0);
    #2 reset = 1'b1;
    #1;
    check("t5.dout", 32'(dout), 32'h0);
    check("t5.dout_valid", 32'(dout_valid), 32'h0);
    model_reset();
    check_state();
    #1 reset = 1'b0;
    r_en = 1'b0;

    // depth 0 selects the whole array
    set_cfg(1'b0, 0);
    for (int i = 0; i < MEM_DEPTH - 1; i++) wr(i * 3 + 1);
    check("t5.not_full", 32'(full), 32'h0);
    wr(16'hBEEF);
    check("t5.full", 32'(full), 32'h1);
    rd(0);
    rd(111);
    rd(MEM_DEPTH - 1);
    wr(16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
